// File: rtl/adc_seq_ctrl.sv
// rtl/adc_seq_ctrl.sv - period-timed three-channel ADC conversion sequencer
// Each period tick runs settle/start/wait for vin, vout, iout and flags timeouts and missed ticks.
module adc_seq_ctrl #(
   parameter int PERIOD_CYC  = 2700,
   parameter int SETTLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        enable,
   output logic [1:0]  adc_ch,
   output logic        adc_start,
   input  logic        adc_done,
   input  logic [11:0] adc_data,
   output logic [11:0] vin_q,
   output logic [11:0] vout_q,
   output logic [11:0] iout_q,
   output logic        sample_valid,
   output logic        timeout_err,
   output logic [7:0]  overrun_cnt,
   input  logic        err_clr
);

   localparam int            PW          = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
   localparam logic [PW-1:0] PER_LAST    = PW'(PERIOD_CYC - 1);
   localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYC - 1);
   localparam logic [7:0]    TMO_LIMIT   = 8'(TIMEOUT_CYC);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_START,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] per_q, per_d;
   logic [7:0]    settle_q, settle_d;
   logic [7:0]    tmo_q, tmo_d;
   logic [7:0]    tmo_inc;
   logic [1:0]    ch_q, ch_d;
   logic [1:0]    adc_ch_q, adc_ch_d;
   logic          adc_start_q, adc_start_d;
   logic          sample_valid_q, sample_valid_d;
   logic          timeout_err_q, timeout_err_d;
   logic [7:0]    overrun_q, overrun_d;
   logic [11:0]   vin_d, vout_d, iout_d;
   logic          tick;
   logic          tmo_evt;
   logic          ovr_evt;

   assign tick    = enable && (per_q == PER_LAST);
   assign tmo_inc = tmo_q + 8'd1;
   assign ovr_evt = tick && (state_q != ST_IDLE);

   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      settle_d = settle_q;
      tmo_d    = tmo_q;
      vin_d    = vin_q;
      vout_d   = vout_q;
      iout_d   = iout_q;
      tmo_evt  = 1'b0;
      per_d    = (!enable || tick) ? '0 : per_q + 1'b1;

      if (!enable) begin
         // Dropping enable aborts wherever we are; nothing is stored or flagged.
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (tick) begin
                  ch_d     = 2'd0;
                  settle_d = 8'd0;
                  state_d  = ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (settle_q == SETTLE_LAST) begin
                  state_d = ST_START;
               end else begin
                  settle_d = settle_q + 8'd1;
               end
            end
            ST_START: begin
               tmo_d   = 8'd0;
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               // A done arriving on the last permitted cycle still counts as success.
               if (adc_done) begin
                  unique case (ch_q)
                     2'd0:    vin_d  = adc_data;
                     2'd1:    vout_d = adc_data;
                     default: iout_d = adc_data;
                  endcase
                  if (ch_q == 2'd2) begin
                     state_d = ST_DONE;
                  end else begin
                     ch_d     = ch_q + 2'd1;
                     settle_d = 8'd0;
                     state_d  = ST_SETTLE;
                  end
               end else if (tmo_inc == TMO_LIMIT) begin
                  tmo_d   = tmo_inc;
                  tmo_evt = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  tmo_d = tmo_inc;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      adc_ch_d = adc_ch_q;
      if ((state_d == ST_SETTLE) && (state_q != ST_SETTLE)) begin
         adc_ch_d = ch_d;
      end

      adc_start_d    = (state_d == ST_START);
      sample_valid_d = (state_d == ST_DONE);

      // New events beat a simultaneous clear so they are never lost.
      if (tmo_evt) begin
         timeout_err_d = 1'b1;
      end else if (err_clr) begin
         timeout_err_d = 1'b0;
      end else begin
         timeout_err_d = timeout_err_q;
      end

      if (err_clr) begin
         overrun_d = {7'd0, ovr_evt};
      end else if (ovr_evt && (overrun_q != 8'hFF)) begin
         overrun_d = overrun_q + 8'd1;
      end else begin
         overrun_d = overrun_q;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         per_q          <= '0;
         settle_q       <= 8'd0;
         tmo_q          <= 8'd0;
         ch_q           <= 2'd0;
         adc_ch_q       <= 2'd0;
         adc_start_q    <= 1'b0;
         sample_valid_q <= 1'b0;
         timeout_err_q  <= 1'b0;
         overrun_q      <= 8'd0;
         vin_q          <= 12'd0;
         vout_q         <= 12'd0;
         iout_q         <= 12'd0;
      end else begin
         state_q        <= state_d;
         per_q          <= per_d;
         settle_q       <= settle_d;
         tmo_q          <= tmo_d;
         ch_q           <= ch_d;
         adc_ch_q       <= adc_ch_d;
         adc_start_q    <= adc_start_d;
         sample_valid_q <= sample_valid_d;
         timeout_err_q  <= timeout_err_d;
         overrun_q      <= overrun_d;
         vin_q          <= vin_d;
         vout_q         <= vout_d;
         iout_q         <= iout_d;
      end
   end

   assign adc_ch       = adc_ch_q;
   assign adc_start    = adc_start_q;
   assign sample_valid = sample_valid_q;
   assign timeout_err  = timeout_err_q;
   assign overrun_cnt  = overrun_q;

endmodule

// File: doc/adc_seq_ctrl.md
ADC_SEQ_CTRL -- requirements
Module: adc_seq_ctrl

Interface
REQ-001 SHALL have parameter PERIOD_CYC, default 2700, sys_clk cycles per control period (10 kHz at 27 MHz).
REQ-002 SHALL have parameter SETTLE_CYC, default 4, mux settling cycles before each conversion start (range 1..255).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, maximum WAIT cycles per conversion (range 1..255).
REQ-004 sys_clk  in  1  system clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 enable  in  1  1 = run period timer and sequencing.
REQ-007 adc_ch  out  2  analog mux/ADC channel select: 0 = vin, 1 = vout, 2 = iout.
REQ-008 adc_start  out  1  single-cycle conversion request to the ADC driver.
REQ-009 adc_done  in  1  single-cycle pulse; adc_data valid in the same cycle.
REQ-010 adc_data  in  12  conversion result, unsigned.
REQ-011 vin_q / vout_q / iout_q  out  12 each  latest stored result per channel.
REQ-012 sample_valid  out  1  single-cycle pulse; all three results from one period are stable.
REQ-013 timeout_err  out  1  sticky conversion-timeout flag.
REQ-014 overrun_cnt  out  8  saturating count of period ticks missed while busy.
REQ-015 err_clr  in  1  synchronous clear of timeout_err and overrun_cnt.

Function
REQ-016 Period counter: 0..PERIOD_CYC-1, wraps to 0; tick = 1 in the cycle the count equals PERIOD_CYC-1; held at 0 while enable=0.
REQ-017 FSM states: IDLE, SETTLE, START, WAIT, DONE; all outputs registered.
REQ-018 IDLE: on tick, load ch=0, clear the settle counter, go to SETTLE; otherwise remain in IDLE.
REQ-019 adc_ch shall update on SETTLE entry and hold through SETTLE, START and WAIT.
REQ-020 SETTLE: remain exactly SETTLE_CYC cycles, then go to START.
REQ-021 START: adc_start=1 for this single cycle only; next state WAIT; clear the timeout counter.
REQ-022 WAIT, adc_done=1: store adc_data into the result register for the current ch at that edge; if ch=2 go to DONE, else ch+1 and go to SETTLE.
REQ-023 WAIT, no adc_done: increment the timeout counter; on reaching TIMEOUT_CYC, set timeout_err=1 and go to IDLE; no sample_valid; results already stored this period are retained.
REQ-024 adc_done and timeout expiry in the same cycle: done wins; no error.
REQ-025 adc_done outside WAIT shall be ignored, with no result update.
REQ-026 DONE: sample_valid=1 for this single cycle, then go to IDLE.
REQ-027 Latency: tick in cycle T -> adc_start high in cycle T+SETTLE_CYC+1 (ch 0).
REQ-028 Tick while the FSM is not in IDLE: ignored for sequencing; overrun_cnt+1, saturating at 255.
REQ-029 enable=0 in any state: FSM shall go to IDLE at the next edge, aborting the sequence; adc_start=0; no error; results retained.
REQ-030 err_clr=1: timeout_err<=0 and overrun_cnt<=0; a timeout or overrun event in the same cycle takes priority (set / count value 1).

Reset
REQ-031 rst_n=0: FSM=IDLE, period/settle/timeout counters=0, ch=0, adc_ch=0, adc_start=0, vin_q=vout_q=iout_q=0, sample_valid=0, timeout_err=0, overrun_cnt=0.
REQ-032 Reset assertion mid-sequence shall abort immediately, with no further adc_start; after release, the first tick shall occur PERIOD_CYC cycles after enable=1 is seen.

Verification (PERIOD_CYC=100, SETTLE_CYC=4, TIMEOUT_CYC=20)
REQ-033 Normal: enable=1; ADC model answers 3 cycles after each start with 0x123/0x456/0x789 -> three adc_start pulses on ch 0,1,2; vin_q=0x123, vout_q=0x456, iout_q=0x789; one sample_valid per period.
REQ-034 Timeout: model never answers ch 1 -> timeout_err=1 exactly 20 cycles after the ch 1 WAIT entry; no sample_valid; vin_q updated; next tick restarts at ch 0.
REQ-035 Overrun: model answers each conversion 40 cycles after start -> sequence spans 2+ ticks; overrun_cnt increments once per missed tick; saturates at 255 after long run; err_clr -> 0.
REQ-036 Boundary: adc_done asserted in the 20th WAIT cycle -> result stored, no timeout_err; stray adc_done in IDLE/SETTLE -> results unchanged.
REQ-037 Abort: enable=0 during ch 1 SETTLE, then reset pulse mid-WAIT -> IDLE next edge, no adc_start or sample_valid; all outputs at reset values; operation resumes cleanly after re-enable.
